// File: rtl/pkt_buffer_writer.sv
// pkt_buffer_writer: takes classified packets as 512-bit flits, allocates a
// pktID from the show-ahead emptylist, writes each flit into the packet buffer
// at (pktID << 5) + flit_index, and emits one metadata record per packet.
module pkt_buffer_writer #(
   parameter int MAX_FLITS     = 31,
   parameter int PKT_AWIDTH    = 9,
   parameter int PKTBUF_AWIDTH = PKT_AWIDTH + 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_pkt_valid,
   input  logic                        in_pkt_sop,
   input  logic                        in_pkt_eop,
   input  logic [511:0]                in_pkt_data,
   input  logic [5:0]                  in_pkt_empty,
   input  logic [2:0]                  in_pkt_flags,
   output logic                        in_pkt_ready,
   input  logic [PKT_AWIDTH-1:0]       emptylist_out_data,
   input  logic                        emptylist_out_valid,
   output logic                        emptylist_out_ready,
   output logic [PKTBUF_AWIDTH-1:0]    pkt_buffer_address,
   output logic                        pkt_buffer_write,
   output logic [519:0]                pkt_buffer_writedata,
   output logic                        meta_valid,
   output logic [PKT_AWIDTH+23:0]      meta_data,
   input  logic                        meta_ready,
   output logic [31:0]                 stat_pkt_cnt,
   output logic [31:0]                 stat_drop_cnt
);

   // Flag encodings shared with the classifier and the data mover.
   localparam logic [2:0] PKT_ETH  = 3'b001;
   localparam logic [2:0] PKT_PCIE = 3'b010;
   localparam logic [2:0] PKT_DROP = 3'b100;
   localparam logic [5:0] MAX_IDX  = 6'(MAX_FLITS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BODY = 2'd1,
      S_EMIT = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic                    w_start;
   logic                    w_body_acc;
   logic                    w_flit_acc;
   logic                    w_do_write;
   logic                    w_over;
   logic                    w_eop_wr;
   logic [5:0]              w_idx;
   logic [2:0]              w_flags;
   logic [PKT_AWIDTH-1:0]   w_pktid;
   logic [15:0]             w_len;

   logic [PKT_AWIDTH-1:0]   r_pktid;
   logic [2:0]              r_flags;
   logic [5:0]              r_cnt;
   logic                    r_trunc;
   logic [5:0]              r_empty;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode: a sop in IDLE opens a packet, eop closes it into EMIT.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_next = in_pkt_eop ? S_EMIT : S_BODY;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_BODY: begin
            if (in_pkt_valid && in_pkt_eop) begin
               w_next = S_EMIT;
            end else begin
               w_next = S_BODY;
            end
         end
         S_EMIT:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM outputs: ingress ready, accepted-sop strobe and emptylist pop.
   always_comb begin
      in_pkt_ready = 1'b0;
      w_start      = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_pkt_ready = !rst && emptylist_out_valid && !meta_valid;
            w_start      = in_pkt_valid && in_pkt_sop && in_pkt_ready;
         end
         S_BODY: begin
            in_pkt_ready = !rst;
            w_start      = 1'b0;
         end
         S_EMIT: begin
            in_pkt_ready = 1'b0;
            w_start      = 1'b0;
         end
         default: begin
            in_pkt_ready = 1'b0;
            w_start      = 1'b0;
         end
      endcase
      emptylist_out_ready = w_start;
   end

   // Per-flit datapath decode: index, effective flags/pktID, write and oversize.
   always_comb begin
      w_idx      = w_start ? 6'd0 : r_cnt;
      w_flags    = w_start ? in_pkt_flags : r_flags;
      w_pktid    = w_start ? emptylist_out_data : r_pktid;
      w_body_acc = (r_state == S_BODY) && in_pkt_valid && in_pkt_ready;
      w_flit_acc = w_start || w_body_acc;
      w_do_write = w_flit_acc && (w_flags != PKT_DROP) && (w_idx < MAX_IDX);
      w_over     = w_flit_acc && (w_idx >= MAX_IDX);
      w_eop_wr   = in_pkt_eop || (w_idx == (MAX_IDX - 6'd1));
      if (r_trunc) begin
         w_len = {5'd0, r_cnt[4:0], 6'd0};
      end else begin
         w_len = {5'd0, r_cnt[4:0], 6'd0} - {10'd0, r_empty};
      end
   end

   // Registered buffer write, packet context, metadata and statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_buffer_write     <= 1'b0;
         pkt_buffer_address   <= '0;
         pkt_buffer_writedata <= '0;
         r_pktid              <= '0;
         r_flags              <= PKT_ETH;
         r_cnt                <= 6'd0;
         r_trunc              <= 1'b0;
         r_empty              <= 6'd0;
         meta_valid           <= 1'b0;
         meta_data            <= '0;
         stat_pkt_cnt         <= 32'd0;
         stat_drop_cnt        <= 32'd0;
      end else begin
         pkt_buffer_write <= w_do_write;
         if (w_do_write) begin
            pkt_buffer_address   <= PKTBUF_AWIDTH'({w_pktid, w_idx[4:0]});
            pkt_buffer_writedata <= {in_pkt_data, in_pkt_sop, w_eop_wr, in_pkt_empty};
         end
         if (w_flit_acc) begin
            r_cnt   <= (w_idx < MAX_IDX) ? (w_idx + 6'd1) : MAX_IDX;
            r_pktid <= w_pktid;
            r_flags <= w_over ? PKT_DROP : w_flags;
            r_trunc <= (w_start ? 1'b0 : r_trunc) | w_over;
            if (in_pkt_eop) begin
               r_empty <= in_pkt_empty;
            end
         end
         // EMIT is only reachable after a sop accepted with meta_valid low.
         if (r_state == S_EMIT) begin
            meta_valid <= 1'b1;
            meta_data  <= {r_pktid, r_cnt[4:0], w_len, r_flags};
         end else if (meta_valid && meta_ready) begin
            meta_valid <= 1'b0;
         end
         if (meta_valid && meta_ready) begin
            stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            if (meta_data[2:0] == PKT_DROP) begin
               stat_drop_cnt <= stat_drop_cnt + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pkt_buffer_writer.sv
// Directed bench for pkt_buffer_writer with hand-computed expectations.
module tb_pkt_buffer_writer;

   localparam logic [2:0] ETH  = 3'b001;
   localparam logic [2:0] PCIE = 3'b010;
   localparam logic [2:0] DROP = 3'b100;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_pkt_valid, in_pkt_sop, in_pkt_eop;
   logic [511:0]  in_pkt_data;
   logic [5:0]    in_pkt_empty;
   logic [2:0]    in_pkt_flags;
   logic          in_pkt_ready;
   logic [8:0]    emptylist_out_data;
   logic          emptylist_out_valid;
   logic          emptylist_out_ready;
   logic [13:0]   pkt_buffer_address;
   logic          pkt_buffer_write;
   logic [519:0]  pkt_buffer_writedata;
   logic          meta_valid;
   logic [32:0]   meta_data;
   logic          meta_ready;
   logic [31:0]   stat_pkt_cnt, stat_drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // write log: {addr, sop, eop, empty, data[31:0]}
   logic [13:0]   wr_addr[$];
   logic [7:0]    wr_ctl[$];
   logic [31:0]   wr_data[$];
   int            wr_cyc[$];
   logic [32:0]   meta_q[$];
   int            meta_rise_cyc;
   int            hs_cyc;
   int            eop_acc_cyc;
   int            sop_acc_cyc;
   int            pops;
   logic          prev_mv;

   pkt_buffer_writer dut (
      .clk                  (clk),
      .rst                  (rst),
      .in_pkt_valid         (in_pkt_valid),
      .in_pkt_sop           (in_pkt_sop),
      .in_pkt_eop           (in_pkt_eop),
      .in_pkt_data          (in_pkt_data),
      .in_pkt_empty         (in_pkt_empty),
      .in_pkt_flags         (in_pkt_flags),
      .in_pkt_ready         (in_pkt_ready),
      .emptylist_out_data   (emptylist_out_data),
      .emptylist_out_valid  (emptylist_out_valid),
      .emptylist_out_ready  (emptylist_out_ready),
      .pkt_buffer_address   (pkt_buffer_address),
      .pkt_buffer_write     (pkt_buffer_write),
      .pkt_buffer_writedata (pkt_buffer_writedata),
      .meta_valid           (meta_valid),
      .meta_data            (meta_data),
      .meta_ready           (meta_ready),
      .stat_pkt_cnt         (stat_pkt_cnt),
      .stat_drop_cnt        (stat_drop_cnt)
   );

   always #5 clk = ~clk;

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // monitor on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         if (emptylist_out_ready) begin
            pops++;
            check("pop_needs_valid", {63'd0, emptylist_out_valid}, 64'd1);
         end
         if (pkt_buffer_write) begin
            wr_addr.push_back(pkt_buffer_address);
            wr_ctl.push_back(pkt_buffer_writedata[7:0]);
            wr_data.push_back(pkt_buffer_writedata[39:8]);
            wr_cyc.push_back(cyc);
         end
         if (in_pkt_valid && in_pkt_ready && in_pkt_eop) eop_acc_cyc = cyc;
         if (in_pkt_valid && in_pkt_ready && in_pkt_sop) sop_acc_cyc = cyc;
         if (meta_valid && !prev_mv) meta_rise_cyc = cyc;
         if (meta_valid && meta_ready) begin
            meta_q.push_back(meta_data);
            hs_cyc = cyc;
         end
         prev_mv = meta_valid;
      end
   end

   task automatic clear_logs();
      wr_addr.delete(); wr_ctl.delete(); wr_data.delete(); wr_cyc.delete();
      meta_q.delete();
      pops = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_flit(input logic sop, input logic eop, input logic [5:0] emp,
                            input logic [2:0] fl, input logic [31:0] dw);
      int n;
      in_pkt_valid = 1'b1;
      in_pkt_sop   = sop;
      in_pkt_eop   = eop;
      in_pkt_empty = emp;
      in_pkt_flags = fl;
      in_pkt_data  = {16{dw}};
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_pkt_ready && n < 200);
      if (!in_pkt_ready) check("ready_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      in_pkt_valid = 1'b0;
      in_pkt_sop   = 1'b0;
      in_pkt_eop   = 1'b0;
   endtask

   function automatic logic [32:0] mk_meta(input logic [8:0] id, input logic [4:0] fl,
                                           input logic [15:0] len, input logic [2:0] f);
      return {id, fl, len, f};
   endfunction

   initial begin
      rst = 1'b1;
      in_pkt_valid = 1'b0; in_pkt_sop = 1'b0; in_pkt_eop = 1'b0;
      in_pkt_data = '0; in_pkt_empty = 6'd0; in_pkt_flags = ETH;
      emptylist_out_data = 9'd0; emptylist_out_valid = 1'b1; meta_ready = 1'b1;
      prev_mv = 1'b0; pops = 0;
      meta_rise_cyc = 0; hs_cyc = 0; eop_acc_cyc = 0; sop_acc_cyc = 0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_ready",  {63'd0, in_pkt_ready}, 64'd0);
      check("rst_pop",    {63'd0, emptylist_out_ready}, 64'd0);
      check("rst_write",  {63'd0, pkt_buffer_write}, 64'd0);
      check("rst_mvalid", {63'd0, meta_valid}, 64'd0);
      check("rst_addr",   {50'd0, pkt_buffer_address}, 64'd0);
      check("rst_meta",   {31'd0, meta_data}, 64'd0);
      check("rst_stats",  {stat_pkt_cnt, stat_drop_cnt}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);

      // T1: single-flit PCIE packet, pktID 7, empty 10
      clear_logs();
      emptylist_out_data = 9'd7;
      send_flit(1'b1, 1'b1, 6'd10, PCIE, 32'hCAFE0001);
      idle(4);
      check("t1_pops", pops, 1);
      check("t1_nwr", wr_addr.size(), 1);
      if (wr_addr.size() == 1) begin
         check("t1_addr", wr_addr[0], 224);
         check("t1_ctl", wr_ctl[0], {1'b1, 1'b1, 6'd10});
         check("t1_data", wr_data[0], 32'hCAFE0001);
         check("t1_wr_lat", wr_cyc[0], eop_acc_cyc + 1);
      end
      check("t1_meta_lat", meta_rise_cyc, eop_acc_cyc + 2);
      check("t1_nmeta", meta_q.size(), 1);
      if (meta_q.size() == 1) check("t1_meta", meta_q[0], mk_meta(9'd7, 5'd1, 16'd54, PCIE));
      check("t1_stat", stat_pkt_cnt, 1);

      // T2: back-to-back 3-flit and 2-flit packets, pktIDs 0 and 1
      clear_logs();
      emptylist_out_data = 9'd0;
      send_flit(1'b1, 1'b0, 6'd0, ETH, 32'h0000A000);
      emptylist_out_data = 9'd1;
      send_flit(1'b0, 1'b0, 6'd0, ETH, 32'h0000A001);
      send_flit(1'b0, 1'b1, 6'd4, ETH, 32'h0000A002);
      send_flit(1'b1, 1'b0, 6'd0, ETH, 32'h0000B000);
      send_flit(1'b0, 1'b1, 6'd0, ETH, 32'h0000B001);
      idle(5);
      check("t2_pops", pops, 2);
      check("t2_nwr", wr_addr.size(), 5);
      if (wr_addr.size() == 5) begin
         check("t2_a0", wr_addr[0], 0);
         check("t2_a1", wr_addr[1], 1);
         check("t2_a2", wr_addr[2], 2);
         check("t2_a3", wr_addr[3], 32);
         check("t2_a4", wr_addr[4], 33);
         check("t2_eop2", wr_ctl[2], {1'b0, 1'b1, 6'd4});
         check("t2_d4", wr_data[4], 32'h0000B001);
      end
      check("t2_nmeta", meta_q.size(), 2);
      if (meta_q.size() == 2) begin
         check("t2_meta0", meta_q[0], mk_meta(9'd0, 5'd3, 16'd188, ETH));
         check("t2_meta1", meta_q[1], mk_meta(9'd1, 5'd2, 16'd128, ETH));
      end
      check("t2_stat", stat_pkt_cnt, 3);

      // T3: 4-flit DROP packet; body flits carry ETH, which must be ignored
      clear_logs();
      emptylist_out_data = 9'd5;
      send_flit(1'b1, 1'b0, 6'd0, DROP, 32'h1);
      send_flit(1'b0, 1'b0, 6'd0, ETH, 32'h2);
      send_flit(1'b0, 1'b0, 6'd0, ETH, 32'h3);
      send_flit(1'b0, 1'b1, 6'd8, ETH, 32'h4);
      idle(5);
      check("t3_nwr", wr_addr.size(), 0);
      check("t3_pops", pops, 1);
      check("t3_nmeta", meta_q.size(), 1);
      if (meta_q.size() == 1) check("t3_meta", meta_q[0], mk_meta(9'd5, 5'd4, 16'd248, DROP));
      check("t3_drop", stat_drop_cnt, 1);

      // T4: 40-flit packet, truncated to 31 writes and marked DROP
      clear_logs();
      emptylist_out_data = 9'd9;
      for (int i = 0; i < 40; i++) begin
         send_flit(i == 0, i == 39, (i == 39) ? 6'd20 : 6'd0, ETH, 32'(i));
      end
      idle(5);
      check("t4_pops", pops, 1);
      check("t4_nwr", wr_addr.size(), 31);
      if (wr_addr.size() == 31) begin
         check("t4_first", wr_addr[0], 288);
         check("t4_last", wr_addr[30], 318);
         check("t4_eop29", {56'd0, wr_ctl[29]}, 64'h00);
         check("t4_eop30", {56'd0, wr_ctl[30]}, 64'h40);
      end
      if (meta_q.size() == 1) check("t4_meta", meta_q[0], mk_meta(9'd9, 5'd31, 16'd1984, DROP));
      else check("t4_nmeta", meta_q.size(), 1);
      check("t4_drop", stat_drop_cnt, 2);

      // T5: meta_ready low for 20 cycles blocks the next sop
      clear_logs();
      meta_ready = 1'b0;
      emptylist_out_data = 9'd11;
      send_flit(1'b1, 1'b1, 6'd0, ETH, 32'h55);
      emptylist_out_data = 9'd12;
      fork
         send_flit(1'b1, 1'b1, 6'd0, ETH, 32'h66);
         begin
            idle(20);
            check("t5_no_early_pop", pops, 1);
            check("t5_mv_held", {63'd0, meta_valid}, 64'd1);
            check("t5_ready_low", {63'd0, in_pkt_ready}, 64'd0);
            meta_ready = 1'b1;
         end
      join
      idle(5);
      check("t5_accept_after_hs", sop_acc_cyc, hs_cyc_first(meta_q.size()) + 1);
      check("t5_pops", pops, 2);
      check("t5_nwr", wr_addr.size(), 2);
      if (wr_addr.size() == 2) check("t5_addrB", wr_addr[1], 384);
      check("t5_stat", stat_pkt_cnt, 7);

      // T6: emptylist empty for 10 cycles while a sop waits
      clear_logs();
      emptylist_out_valid = 1'b0;
      emptylist_out_data = 9'd13;
      fork
         send_flit(1'b1, 1'b1, 6'd2, ETH, 32'h77);
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               check("t6_ready_low", {63'd0, in_pkt_ready}, 64'd0);
            end
            check("t6_no_write", wr_addr.size(), 0);
            @(posedge clk); #1;
            emptylist_out_valid = 1'b1;
         end
      join
      idle(5);
      check("t6_pops", pops, 1);
      check("t6_nwr", wr_addr.size(), 1);
      if (wr_addr.size() == 1) check("t6_addr", wr_addr[0], 416);
      if (meta_q.size() == 1) check("t6_meta", meta_q[0], mk_meta(9'd13, 5'd1, 16'd62, ETH));
      else check("t6_nmeta", meta_q.size(), 1);
      check("final_pkt_cnt", stat_pkt_cnt, 8);
      check("final_drop_cnt", stat_drop_cnt, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Cycle of packet A's handshake: hs_cyc is overwritten by B's handshake,
   // so A's is recovered as B's accept reference only when A alone has been seen.
   int hs_a_cyc = -100;
   always @(negedge clk) begin
      if (!rst && meta_valid && meta_ready && meta_data[32:24] == 9'd11) hs_a_cyc = cyc;
   end

   function automatic int hs_cyc_first(input int unused_n);
      return hs_a_cyc + 0 * unused_n;
   endfunction

endmodule
